// File: rtl/hls_mul_pkg.sv
// Purpose: shared constants and result-range helpers for the pipelined multiplier.
// Contents: legal parameter ranges, the internal working width, and helpers that
//   test whether a widened result fits the output width and that produce the
//   clamp value when it does not.
package hls_mul_pkg;

  localparam int unsigned NUM_STAGE_MIN = 1;
  localparam int unsigned NUM_STAGE_MAX = 8;
  // Working width for range checks; product plus rounding bit must fit here.
  localparam int unsigned MAX_W         = 64;
  localparam int unsigned IDX_W         = $clog2(MAX_W);

  // True when v is the sign (sgn=1) or zero (sgn=0) extension of its low dw bits.
  function automatic logic fits_dout(input logic [MAX_W-1:0] v,
                                     input int unsigned      dw,
                                     input logic             sgn);
    logic ext;
    fits_dout = 1'b1;
    ext       = sgn ? v[IDX_W'(dw - 1)] : 1'b0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i >= dw && v[IDX_W'(i)] != ext) fits_dout = 1'b0;
    end
  endfunction

  // Clamp value for an out-of-range v: max of the dw-bit range, or min when v is negative.
  function automatic logic [MAX_W-1:0] sat_value(input logic [MAX_W-1:0] v,
                                                 input int unsigned      dw,
                                                 input logic             sgn);
    if (!sgn)               sat_value = ~({MAX_W{1'b1}} << dw);
    else if (v[MAX_W-1])    sat_value = {MAX_W{1'b1}} << (dw - 1);
    else                    sat_value = ~({MAX_W{1'b1}} << (dw - 1));
  endfunction

endpackage

// File: rtl/hls_mul_if.sv
// Purpose: operand/result bundle of the pipelined multiplier.
// Signals: in_valid/din0/din1 (operand pair, master -> slave),
//          out_valid/dout/ovf (result, slave -> master).
interface hls_mul_if #(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 16,
  parameter int unsigned DOUT_WIDTH = 16
);

  logic                  in_valid;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  ovf;

  modport master (output in_valid, din0, din1, input out_valid, dout, ovf);
  modport slave  (input in_valid, din0, din1, output out_valid, dout, ovf);

endinterface

// File: rtl/hls_mul_pipe_dsp.sv
// Purpose: multiply core with operand and product registers, shaped for DSP mapping.
// Ports: clk, reset (sync, active-high), ce (clock enable), in_valid/din0/din1 (operands),
//        prod_valid/prod (full-width product after LAT enabled edges; LAT=0 is combinational).
module hls_mul_pipe_dsp
  import hls_mul_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH  = 16,
  parameter int unsigned DIN1_WIDTH  = 16,
  parameter int unsigned SIGNED_MODE = 1,
  parameter int unsigned LAT         = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic                             in_valid,
  input  logic [DIN0_WIDTH-1:0]            din0,
  input  logic [DIN1_WIDTH-1:0]            din1,
  output logic                             prod_valid,
  output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] prod
);

  localparam int unsigned P = DIN0_WIDTH + DIN1_WIDTH;

  logic [DIN0_WIDTH-1:0] a_src;
  logic [DIN1_WIDTH-1:0] b_src;
  logic [P-1:0]          mult_c;

  // Exact product: operands extended to P bits before multiplying.
  always_comb begin
    mult_c = '0;
    if (SIGNED_MODE != 0) mult_c = P'($signed(a_src)) * P'($signed(b_src));
    else                  mult_c = P'(a_src) * P'(b_src);
  end

  if (LAT == 0) begin : g_comb
    assign a_src      = din0;
    assign b_src      = din1;
    assign prod       = mult_c;
    assign prod_valid = in_valid;
  end else begin : g_reg
    logic [DIN0_WIDTH-1:0] a_q, a_d;
    logic [DIN1_WIDTH-1:0] b_q, b_d;
    logic [LAT-1:0]        vld_q, vld_d;

    // Operand registers plus the valid shift register for the whole core.
    always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      vld_d = vld_q;
      if (ce) begin
        a_d   = din0;
        b_d   = din1;
        vld_d = LAT'({vld_q, in_valid});
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        a_q   <= '0;
        b_q   <= '0;
        vld_q <= '0;
      end else begin
        a_q   <= a_d;
        b_q   <= b_d;
        vld_q <= vld_d;
      end
    end

    assign a_src      = a_q;
    assign b_src      = b_q;
    assign prod_valid = vld_q[LAT-1];

    if (LAT == 1) begin : g_m0
      assign prod = mult_c;
    end else begin : g_m
      localparam int unsigned MS = LAT - 1;
      logic [MS-1:0][P-1:0] m_q, m_d;

      // Product delay line; newest product enters at index 0.
      always_comb begin
        m_d = m_q;
        if (ce) m_d = (MS*P)'({m_q, mult_c});
      end

      always_ff @(posedge clk) begin
        if (reset) m_q <= '0;
        else       m_q <= m_d;
      end

      assign prod = m_q[MS-1];
    end
  end

endmodule

// File: rtl/hls_mul_pipe.sv
// Purpose: pipelined multiplier with fixed-point scaling, optional rounding and
//   saturate-or-wrap output, NUM_STAGE enabled cycles of latency.
// Ports: clk, reset (sync, active-high), ce (freezes all registers when low),
//        bus (slave side: in_valid/din0/din1 in, out_valid/dout/ovf out, all registered).
module hls_mul_pipe
  import hls_mul_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH  = 16,
  parameter int unsigned DIN1_WIDTH  = 16,
  parameter int unsigned DOUT_WIDTH  = 16,
  parameter int unsigned NUM_STAGE   = 3,
  parameter int unsigned SIGNED_MODE = 1,
  parameter int unsigned FRAC_SHIFT  = 0,
  parameter int unsigned ROUND_EN    = 0,
  parameter int unsigned SAT_EN      = 0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      ce,
  hls_mul_if.slave  bus
);

  localparam int unsigned P  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned P1 = P + 1;
  // Half an output LSB; zero when FRAC_SHIFT is 0.
  localparam logic [P1-1:0] RND_ADD = (ROUND_EN != 0) ? (P1'(1) << FRAC_SHIFT) >> 1 : '0;

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("hls_mul_pipe: NUM_STAGE out of range");
  end
  if (DIN0_WIDTH == 0 || DIN1_WIDTH == 0 || DOUT_WIDTH == 0 ||
      P1 > MAX_W || DOUT_WIDTH > MAX_W) begin : g_bad_width
    $error("hls_mul_pipe: operand or result width out of range");
  end
  if (FRAC_SHIFT > P - 1) begin : g_bad_shift
    $error("hls_mul_pipe: FRAC_SHIFT out of range");
  end
  if (SIGNED_MODE > 1 || ROUND_EN > 1 || SAT_EN > 1) begin : g_bad_mode
    $error("hls_mul_pipe: mode parameter must be 0 or 1");
  end

  logic                  prod_valid;
  logic [P-1:0]          prod;
  logic [P1-1:0]         ext_c, rnd_c, shf_c;
  logic [MAX_W-1:0]      wide_c;
  logic                  fit_c;
  logic [DOUT_WIDTH-1:0] res_c;

  logic                  out_valid_q, out_valid_d;
  logic [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;

  // All stages but the last live in the multiply core.
  hls_mul_pipe_dsp #(
    .DIN0_WIDTH  (DIN0_WIDTH),
    .DIN1_WIDTH  (DIN1_WIDTH),
    .SIGNED_MODE (SIGNED_MODE),
    .LAT         (NUM_STAGE - 1)
  ) u_dsp (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .in_valid   (bus.in_valid),
    .din0       (bus.din0),
    .din1       (bus.din1),
    .prod_valid (prod_valid),
    .prod       (prod)
  );

  // Last stage: extend by one bit, round, shift, then check range against the output width.
  always_comb begin
    ext_c  = '0;
    shf_c  = '0;
    wide_c = '0;
    if (SIGNED_MODE != 0) ext_c = P1'($signed(prod));
    else                  ext_c = P1'(prod);
    rnd_c = ext_c + RND_ADD;
    if (SIGNED_MODE != 0) begin
      shf_c  = P1'($signed(rnd_c) >>> FRAC_SHIFT);
      wide_c = MAX_W'($signed(shf_c));
    end else begin
      shf_c  = rnd_c >> FRAC_SHIFT;
      wide_c = MAX_W'(shf_c);
    end
    fit_c = fits_dout(wide_c, DOUT_WIDTH, SIGNED_MODE != 0);
    if (SAT_EN != 0 && !fit_c) res_c = DOUT_WIDTH'(sat_value(wide_c, DOUT_WIDTH, SIGNED_MODE != 0));
    else                       res_c = DOUT_WIDTH'(wide_c);
  end

  // Output register next-state; held while ce is low.
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (ce) begin
      out_valid_d = prod_valid;
      dout_d      = res_c;
      ovf_d       = !fit_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/hls_mul_pipe.md
HLS_MUL_PIPE -- requirements
Module: hls_mul_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 16, width of operand din0.
REQ-002 SHALL have parameter DIN1_WIDTH, default 16, width of operand din1.
REQ-003 SHALL have parameter DOUT_WIDTH, default 16, width of result dout.
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline latency in enabled cycles (legal 1..8).
REQ-005 SHALL have parameter SIGNED_MODE, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have parameter FRAC_SHIFT, default 0, right shift applied to the full product (legal 0..DIN0_WIDTH+DIN1_WIDTH-1).
REQ-007 SHALL have parameter ROUND_EN, default 0: 1 = round half-up before the shift.
REQ-008 SHALL have parameter SAT_EN, default 0: 1 = saturate to the dout range, 0 = wrap (keep the low bits).
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 ce  in  1  clock enable; 0 freezes every register.
REQ-012 in_valid  in  1  din0/din1 carry a valid operand pair this cycle.
REQ-013 din0  in  DIN0_WIDTH  multiplicand.
REQ-014 din1  in  DIN1_WIDTH  multiplier.
REQ-015 out_valid  out  1  dout/ovf carry a valid result.
REQ-016 dout  out  DOUT_WIDTH  scaled, rounded, saturated-or-wrapped product.
REQ-017 ovf  out  1  the result for this out_valid did not fit in DOUT_WIDTH.

Function
REQ-018 Full product SHALL be computed exactly in P = DIN0_WIDTH+DIN1_WIDTH bits, signed or unsigned per SIGNED_MODE.
REQ-019 If ROUND_EN=1 and FRAC_SHIFT>0, 2^(FRAC_SHIFT-1) SHALL be added to the product in P+1 bits before the shift.
REQ-020 The shift SHALL be arithmetic when SIGNED_MODE=1 and logical otherwise.
REQ-021 SAT_EN=1: a shifted value above max/below min of DOUT_WIDTH SHALL clamp to max/min with ovf=1; otherwise ovf=0.
REQ-022 SAT_EN=0: dout SHALL be the low DOUT_WIDTH bits, with ovf=1 iff the discarded upper bits are not the sign/zero extension of dout.
REQ-023 A pair accepted with in_valid=1 on an edge where ce=1 SHALL appear on out_valid/dout exactly NUM_STAGE ce=1 edges later.
REQ-024 Throughput SHALL be one pair per ce=1 cycle; back-to-back pairs SHALL NOT interfere.
REQ-025 in_valid SHALL propagate through a NUM_STAGE-deep valid shift register in lockstep with the data.
REQ-026 ce=0 SHALL hold all data, valid and ovf registers; outputs stay stable while stalled.
REQ-027 in_valid=0 slots SHALL produce out_valid=0; dout/ovf in those slots are don't-care but SHALL be deterministic.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 reset=1 at an edge SHALL clear every valid stage, dout and ovf to 0, regardless of ce.
REQ-030 Reset mid-operation SHALL discard all in-flight results; none SHALL emerge afterwards.
REQ-031 A pair presented with in_valid=1 on the reset edge SHALL be dropped.
REQ-032 The first pair accepted after reset deasserts SHALL emerge after exactly NUM_STAGE ce=1 edges.

Structure
REQ-033 Package hls_mul_pkg SHALL hold the legal-range constants (max NUM_STAGE = 8) and the saturation/overflow helper functions.
REQ-034 Sub-module hls_mul_pipe_dsp SHALL contain the multiply plus input/product registers (DSP48-mappable); scaling, rounding and saturation SHALL be implemented in the last stage of the top level.
REQ-035 Illegal parameter values SHALL fail at elaboration.

Verification
REQ-036 Defaults: din0=3, din1=-4 (0xFFFC), ce=1 -> out_valid after 3 cycles, dout=0xFFF4, ovf=0.
REQ-037 Defaults: din0=din1=0x8000 -> dout=0x0000, ovf=1; with SAT_EN=1 -> dout=0x7FFF, ovf=1.
REQ-038 FRAC_SHIFT=8, ROUND_EN=1: 0x0180*0x0100 -> 0x0180; 0x0001*0x0080 -> 0x0001; 0xFFFF*0x0080 -> 0x0000.
REQ-039 SIGNED_MODE=0: 0xFFFF*0x0002 -> dout=0xFFFE, ovf=1; with SAT_EN=1 -> 0xFFFF, ovf=1.
REQ-040 Stream 10 back-to-back pairs with ce low for 2 cycles mid-stream -> 10 results in order, each delayed by 3 plus the stall cycles, outputs held during the stall.
REQ-041 Assert reset for 1 cycle with 2 pairs in flight -> out_valid stays 0 until a new pair arrives, which emerges after 3 cycles.
